da_sequencer: RTL and testbench

DA_SEQUENCER -- requirements
Module: da_sequencer

---
 rtl/da_sequencer_if.sv | 53 +++++
 rtl/da_sequencer.sv | 141 ++++++++++++++
 tb/tb_da_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/da_sequencer_if.sv
// rtl/da_sequencer_if.sv - handshake/bus bundle between the DA sequencer and its environment
//
// Purpose: groups every non-clock/reset signal of da_sequencer.
//   master modport: environment side (drives cload, lut_data_valid, valid_in, ready_out)
//   slave modport : sequencer side (drives LUT write, datapath strobes, status)
// Signals:
//   cload          - request (re)load of the DA LUT, level-sampled
//   lut_data_valid - LUT word present on the coefficient bus
//   lut_data_ready - sequencer accepting LUT words
//   lut_we/lut_addr- LUT write strobe and address
//   valid_in/ready_in   - input sample handshake
//   fifo_en        - advance tap delay line, parallel-load serializers
//   shift_en       - shift serializers one bit, LSB first
//   acc_clr/acc_en/acc_sub - accumulator control, acc_sub on the sign bit
//   bit_cnt        - current bit index
//   valid_out/ready_out - result handshake
//   busy/lut_loaded     - activity and LUT-complete status
interface da_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 4
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic             cload;
  logic             lut_data_valid;
  logic             lut_data_ready;
  logic             lut_we;
  logic [TAPS-1:0]  lut_addr;
  logic             valid_in;
  logic             ready_in;
  logic             fifo_en;
  logic             shift_en;
  logic             acc_clr;
  logic             acc_en;
  logic             acc_sub;
  logic [CNT_W-1:0] bit_cnt;
  logic             valid_out;
  logic             ready_out;
  logic             busy;
  logic             lut_loaded;

  modport master (
    output cload, lut_data_valid, valid_in, ready_out,
    input  lut_data_ready, lut_we, lut_addr, ready_in, fifo_en, shift_en,
           acc_clr, acc_en, acc_sub, bit_cnt, valid_out, busy, lut_loaded
  );

  modport slave (
    input  cload, lut_data_valid, valid_in, ready_out,
    output lut_data_ready, lut_we, lut_addr, ready_in, fifo_en, shift_en,
           acc_clr, acc_en, acc_sub, bit_cnt, valid_out, busy, lut_loaded
  );
endinterface

// File: rtl/da_sequencer.sv
// rtl/da_sequencer.sv - control sequencer for a bit-serial distributed-arithmetic filter
//
// Purpose: loads the 2^TAPS-entry DA LUT from the coefficient bus, then for each
// accepted sample drives DATA_W bit-serial accumulate cycles (subtracting on the
// two's-complement sign bit) and presents the result with a valid/ready handshake.
// Ports:
//   clk    - sole clock, rising edge
//   resetn - synchronous active-low reset
//   bus    - da_sequencer_if.slave, all handshake/datapath control signals
module da_sequencer #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 4
) (
  input  logic           clk,
  input  logic           resetn,
  da_sequencer_if.slave  bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TAPS-1:0]  LAST_ADDR = '1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_RUN  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TAPS-1:0]  load_cnt;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             loaded_q;

  logic enter_load;
  logic last_word;
  logic last_bit;
  logic accept;

  // cload only matters in IDLE and WAIT; LOAD/RUN/HOLD ignore it.
  assign enter_load = ((state == S_IDLE) || (state == S_WAIT)) && bus.cload;
  assign last_word  = (state == S_LOAD) && bus.lut_data_valid && (load_cnt == LAST_ADDR);
  assign last_bit   = (state == S_RUN) && (bit_cnt_q == LAST_BIT);
  // A reload request in WAIT wins over a sample offered in the same cycle.
  assign accept     = (state == S_WAIT) && !bus.cload && bus.valid_in;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.cload) state_nxt = S_LOAD;
      S_LOAD: if (last_word) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.cload)     state_nxt = S_LOAD;
        else if (accept)   state_nxt = S_RUN;
      end
      S_RUN:  if (last_bit) state_nxt = S_HOLD;
      S_HOLD: if (bus.ready_out) state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load address counter, bit counter and LUT-complete flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      load_cnt  <= '0;
      bit_cnt_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      if (enter_load) begin
        load_cnt <= '0;
      end else if ((state == S_LOAD) && bus.lut_data_valid) begin
        // All-ones address wraps back to 0 as the load completes.
        load_cnt <= load_cnt + 1'b1;
      end

      if (state == S_RUN) begin
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
      end else begin
        bit_cnt_q <= '0;
      end

      if (enter_load) begin
        loaded_q <= 1'b0;
      end else if (last_word) begin
        loaded_q <= 1'b1;
      end
    end
  end

  // Output decode: strobes come from state/counters; only lut_we, fifo_en,
  // acc_clr and ready_in look at inputs, and those are meant to be combinational.
  always_comb begin
    bus.lut_data_ready = 1'b0;
    bus.lut_we         = 1'b0;
    bus.lut_addr       = load_cnt;
    bus.ready_in       = 1'b0;
    bus.fifo_en        = 1'b0;
    bus.acc_clr        = 1'b0;
    bus.shift_en       = 1'b0;
    bus.acc_en         = 1'b0;
    bus.acc_sub        = 1'b0;
    bus.bit_cnt        = bit_cnt_q;
    bus.valid_out      = 1'b0;
    bus.busy           = 1'b0;
    bus.lut_loaded     = loaded_q;
    case (state)
      S_LOAD: begin
        bus.lut_data_ready = 1'b1;
        bus.lut_we         = bus.lut_data_valid;
        bus.busy           = 1'b1;
      end
      S_WAIT: begin
        bus.ready_in = !bus.cload;
        bus.fifo_en  = accept;
        bus.acc_clr  = accept;
      end
      S_RUN: begin
        bus.shift_en = 1'b1;
        bus.acc_en   = 1'b1;
        bus.acc_sub  = last_bit;
        bus.busy     = 1'b1;
      end
      S_HOLD: begin
        bus.valid_out = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_da_sequencer.sv
// tb/tb_da_sequencer.sv - self-checking bench for da_sequencer against a phase/timestamp model
module tb_da_sequencer;
  localparam int DATA_W = 16;
  localparam int TAPS   = 4;
  localparam int DEPTH  = 1 << TAPS;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_WAIT = 2;
  localparam int P_RUN  = 3;
  localparam int P_HOLD = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  da_sequencer_if #(.DATA_W(DATA_W), .TAPS(TAPS)) bus();
  da_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: which phase the sequencer should be in, words written so far,
  // whether a full LUT is held, and the cycle a sample was accepted.
  int ph       = P_IDLE;
  int words    = 0;
  bit loaded   = 1'b0;
  int t_acc    = 0;
  int we_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit c, input bit ldv, input bit vin, input bit rout, input bit rst_n);
    logic e_ldr, e_we, e_rin, e_fifo, e_shift, e_sub, e_vout, e_busy;
    int   e_addr, e_bit;
    @(negedge clk);
    bus.cload          = c;
    bus.lut_data_valid = ldv;
    bus.valid_in       = vin;
    bus.ready_out      = rout;
    resetn             = rst_n;
    #1;
    e_ldr = 0; e_we = 0; e_rin = 0; e_fifo = 0; e_shift = 0; e_sub = 0;
    e_vout = 0; e_busy = 0; e_addr = 0; e_bit = 0;
    case (ph)
      P_LOAD: begin e_ldr = 1; e_we = ldv; e_addr = words; e_busy = 1; end
      P_WAIT: begin e_rin = !c; e_fifo = vin && !c; end
      P_RUN: begin
        e_shift = 1; e_busy = 1;
        e_bit   = cyc - t_acc - 1;
        e_sub   = (e_bit == DATA_W - 1);
      end
      P_HOLD: begin e_vout = 1; e_busy = 1; end
      default: ;
    endcase
    check_eq("lut_data_ready", bus.lut_data_ready, e_ldr);
    check_eq("lut_we", bus.lut_we, e_we);
    check_eq("lut_addr", bus.lut_addr, e_addr);
    check_eq("ready_in", bus.ready_in, e_rin);
    check_eq("fifo_en", bus.fifo_en, e_fifo);
    check_eq("acc_clr", bus.acc_clr, e_fifo);
    check_eq("shift_en", bus.shift_en, e_shift);
    check_eq("acc_en", bus.acc_en, e_shift);
    check_eq("acc_sub", bus.acc_sub, e_sub);
    check_eq("bit_cnt", bus.bit_cnt, e_bit);
    check_eq("valid_out", bus.valid_out, e_vout);
    check_eq("busy", bus.busy, e_busy);
    check_eq("lut_loaded", bus.lut_loaded, loaded);
    if (bus.lut_we === 1'b1) we_count++;

    // Model advance at the coming rising edge
    if (!rst_n) begin
      ph = P_IDLE; words = 0; loaded = 0;
    end else begin
      case (ph)
        P_IDLE: if (c) begin ph = P_LOAD; words = 0; loaded = 0; end
        P_LOAD: if (ldv) begin
          if (words == DEPTH - 1) begin ph = P_WAIT; words = 0; loaded = 1; end
          else words++;
        end
        P_WAIT: begin
          if (c) begin ph = P_LOAD; words = 0; loaded = 0; end
          else if (vin) begin ph = P_RUN; t_acc = cyc; end
        end
        P_RUN:  if (cyc - t_acc == DATA_W) ph = P_HOLD;
        P_HOLD: if (rout) ph = P_WAIT;
        default: ;
      endcase
    end
    cyc++;
  endtask

  initial begin
    // Unknown state until the first reset edge; checking starts afterwards.
    resetn = 1'b0;
    bus.cload = 1'b1; bus.lut_data_valid = 1'b0; bus.valid_in = 1'b1; bus.ready_out = 1'b0;
    @(posedge clk);

    // Reset held with cload/valid_in high
    repeat (3) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);

    // LUT load with lut_data_valid every other cycle
    step(1, 0, 0, 0, 1);
    we_count = 0;
    for (int i = 0; i < 2 * DEPTH; i++) step(0, i[0], 0, 0, 1);
    check_eq("load_we_pulses", we_count, DEPTH);
    step(0, 0, 0, 0, 1);

    // Single sample, then backpressure in HOLD with valid_in held high
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < DATA_W; i++) step(0, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1);

    // cload and valid_in together in WAIT
    step(1, 0, 1, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 1);

    // Reset at bit_cnt = 7
    step(0, 0, 1, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 25; i++) step(0, 1, 1, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 299) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
